// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between an upstream producer, a pipe_stage_reg and its downstream consumer.
// The master drives payload/flow control into the stage; the slave is the stage itself.
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 115
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and a configurable bubble value shown whenever the stage is empty.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH  = 115,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             accept;
  logic             pop;

  assign accept = bus.in_valid && in_ready_q;
  assign pop    = out_valid_q && bus.out_ready;

  // State and storage registers; ready/valid flops are derived from the next state
  // so neither output depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = ONE;
      ONE: begin
        if (accept && !pop)      state_d = FULL;
        else if (!accept && pop) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (bus.flush) state_d = EMPTY;
  end

  // Storage updates; vacated entries are refilled with the bubble so the head never shows stale data.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (bus.flush) begin
      main_d = BUBBLE;
      skid_d = BUBBLE;
    end else begin
      case (state_q)
        EMPTY: if (accept) main_d = bus.in_data;
        ONE: begin
          if (accept && pop)       main_d = bus.in_data;
          else if (accept && !pop) skid_d = bus.in_data;
          else if (pop)            main_d = BUBBLE;
        end
        FULL: begin
          if (pop) begin
            main_d = skid_q;
            skid_d = BUBBLE;
          end
        end
        default: begin
          main_d = BUBBLE;
          skid_d = BUBBLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.occupancy = state_q;

endmodule
